// File: rtl/conv_freq_mac.sv
// Frequency-domain complex multiply-accumulate between the forward and inverse 2-D FFTs.
// Buses pack 64 complex elements [tile][row][col]: element 0 sits in the MSBs, and each element is {r[31:0], i[31:0]}.
module conv_freq_mac #(
    parameter int FRAC_BITS = 16,
    parameter int ACC_W     = 40,
    parameter int CH_W      = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH_W-1:0] num_ch,
    input  logic            in_next,
    input  logic [4095:0]   in,
    input  logic [4095:0]   kernel,
    output logic            out_next,
    output logic [4095:0]   out,
    output logic            busy
);
    localparam int DATA_W = 32;
    localparam int CPLX_W = 2 * DATA_W;
    localparam int NE     = 64;
    localparam int BUS_W  = NE * CPLX_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] scale_prod(input logic signed [63:0] p);
        logic signed [63:0] s;
        s = p >>> FRAC_BITS;
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [2*ACC_W-1:0] cmul(input logic [CPLX_W-1:0] a, input logic [CPLX_W-1:0] b);
        logic signed [63:0] ar, ai, br, bi, pr, pi;
        ar = $signed(a[CPLX_W-1:DATA_W]);
        ai = $signed(a[DATA_W-1:0]);
        br = $signed(b[CPLX_W-1:DATA_W]);
        bi = $signed(b[DATA_W-1:0]);
        pr = ar * br - ai * bi;
        pi = ar * bi + ai * br;
        return {scale_prod(pr), scale_prod(pi)};
    endfunction

    function automatic logic [DATA_W-1:0] sat32(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (a < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        return a[DATA_W-1:0];
    endfunction

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t          r_state, w_state_nxt;
    logic [CH_W-1:0] r_chan_cnt, w_cnt_nxt, r_n, w_n_nxt;
    logic            w_first, w_last;

    logic                    r_vld_p0, r_first_p0, r_last_p0;
    logic                    r_vld_p1, r_first_p1, r_last_p1;
    logic                    r_vld_p2, r_last_p2;
    logic signed [ACC_W-1:0] w_pr [NE];
    logic signed [ACC_W-1:0] w_pi [NE];
    logic signed [ACC_W-1:0] r_pr_p1 [NE];
    logic signed [ACC_W-1:0] r_pi_p1 [NE];
    logic signed [ACC_W-1:0] r_acc_r_p2 [NE];
    logic signed [ACC_W-1:0] r_acc_i_p2 [NE];
    logic [BUS_W-1:0]        r_out;

    // Channel counter: the group size is latched on the first beat, so later num_ch changes are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_chan_cnt;
        w_n_nxt     = r_n;
        w_first     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: if (in_next) begin
                w_n_nxt = (num_ch == '0) ? CH_W'(1) : num_ch;
                w_first = 1'b1;
                w_last  = (w_n_nxt == CH_W'(1));
                if (!w_last) begin
                    w_cnt_nxt   = CH_W'(1);
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: if (in_next) begin
                w_last = (r_chan_cnt == r_n - CH_W'(1));
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_chan_cnt + CH_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_chan_cnt <= '0;
            r_n        <= CH_W'(1);
        end else begin
            r_state    <= w_state_nxt;
            r_chan_cnt <= w_cnt_nxt;
            r_n        <= w_n_nxt;
        end
    end

    always_comb begin
        for (int e = 0; e < NE; e++) begin
            {w_pr[e], w_pi[e]} = cmul(in[BUS_W-1-CPLX_W*e -: CPLX_W], kernel[BUS_W-1-CPLX_W*e -: CPLX_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p0 <= in_next;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
        r_first_p0 <= w_first;
        r_last_p0  <= w_last;
        r_first_p1 <= r_first_p0;
        r_last_p1  <= r_last_p0;
        r_last_p2  <= r_last_p1;
    end

    // Stage P registers the products; stage A loads on a group's first beat and accumulates on later beats.
    always_ff @(posedge clk) begin
        for (int e = 0; e < NE; e++) begin
            r_pr_p1[e] <= w_pr[e];
            r_pi_p1[e] <= w_pi[e];
            if (r_vld_p1) begin
                r_acc_r_p2[e] <= r_first_p1 ? r_pr_p1[e] : r_acc_r_p2[e] + r_pr_p1[e];
                r_acc_i_p2[e] <= r_first_p1 ? r_pi_p1[e] : r_acc_i_p2[e] + r_pi_p1[e];
            end
        end
    end

    assign out_next = r_vld_p2 & r_last_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (out_next) begin
            for (int e = 0; e < NE; e++) begin
                r_out[BUS_W-1-CPLX_W*e -: DATA_W]        <= sat32(r_acc_r_p2[e]);
                r_out[BUS_W-1-CPLX_W*e-DATA_W -: DATA_W] <= sat32(r_acc_i_p2[e]);
            end
        end
    end

    assign out  = r_out;
    assign busy = (r_chan_cnt != '0) | r_vld_p0 | r_vld_p1 | r_vld_p2;

endmodule

// File: tb/tb_conv_freq_mac.sv
// Directed bench for conv_freq_mac: pulse timing, accumulation, saturation, group chaining and reset abort.
module tb_conv_freq_mac;
    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    num_ch;
    logic          in_next;
    logic [4095:0] in_v;
    logic [4095:0] ker_v;
    logic          out_next;
    logic [4095:0] out_v;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] HALF = 32'h0000_8000;

    conv_freq_mac dut (
        .clk(clk), .reset(reset), .num_ch(num_ch), .in_next(in_next),
        .in(in_v), .kernel(ker_v), .out_next(out_next), .out(out_v), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_el(input int e, input logic [31:0] ar, input logic [31:0] ai,
                          input logic [31:0] br, input logic [31:0] bi);
        in_v[4095-64*e -: 64]  = {ar, ai};
        ker_v[4095-64*e -: 64] = {br, bi};
    endtask

    function automatic logic [63:0] get_el(input logic [4095:0] v, input int e);
        return v[4095-64*e -: 64];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; num_ch = '0; in_next = 1'b0; in_v = '0; ker_v = '0;
        step(); step(); step();
        reset = 1'b0;
        chk("reset_out", get_el(out_v, 0), 64'h0);
        chk("reset_out_next", 64'(out_next), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);

        // N=1: (1,2)*(3,-1) = (5,5)
        step(); num_ch = 10'd1; in_next = 1'b1;
        step(); in_next = 1'b0; set_el(0, ONE, 32'h0002_0000, 32'h0003_0000, 32'hFFFF_0000);
        chk("t1_next_T1", 64'(out_next), 64'h0);
        step(); chk("t1_next_T2", 64'(out_next), 64'h0);
        step(); chk("t1_next_T3", 64'(out_next), 64'h1);
        step(); chk("t1_next_T4", 64'(out_next), 64'h0);
        chk("t1_out0", get_el(out_v, 0), {32'h0005_0000, 32'h0005_0000});
        chk("t1_out63", get_el(out_v, 63), 64'h0);
        chk("t1_busy", 64'(busy), 64'h0);

        // N=4: four beats of (1,0)*(0.5,0.5) = (2,2) in every element
        for (int e = 0; e < 64; e++) set_el(e, ONE, 32'h0, HALF, HALF);
        step(); num_ch = 10'd4; in_next = 1'b1;
        step();
        chk("t2_busy_mid", 64'(busy), 64'h1);
        step(); step();
        step(); in_next = 1'b0;
        chk("t2_next_P1", 64'(out_next), 64'h0);
        step(); chk("t2_next_P2", 64'(out_next), 64'h0);
        step(); chk("t2_next_P3", 64'(out_next), 64'h1);
        step(); chk("t2_next_P4", 64'(out_next), 64'h0);
        chk("t2_out0", get_el(out_v, 0), {32'h0002_0000, 32'h0002_0000});
        chk("t2_out21", get_el(out_v, 21), {32'h0002_0000, 32'h0002_0000});
        chk("t2_out63", get_el(out_v, 63), {32'h0002_0000, 32'h0002_0000});
        chk("t2_busy_end", 64'(busy), 64'h0);

        // Saturation, positive then negative
        in_v = '0; ker_v = '0;
        set_el(0, 32'h7FFF_0000, 32'h0, 32'h0002_0000, 32'h0);
        step(); num_ch = 10'd2; in_next = 1'b1;
        step();
        step(); in_next = 1'b0;
        step(); step(); chk("t3_pos_next", 64'(out_next), 64'h1);
        step(); chk("t3_pos_out", get_el(out_v, 0), {32'h7FFF_FFFF, 32'h0});
        set_el(0, 32'h8001_0000, 32'h0, 32'h0002_0000, 32'h0);
        step(); in_next = 1'b1;
        step();
        step(); in_next = 1'b0;
        step(); step(); chk("t3_neg_next", 64'(out_next), 64'h1);
        step(); chk("t3_neg_out", get_el(out_v, 0), {32'h8000_0000, 32'h0});

        // Back-to-back groups of two: products (1,0) then (3,0)
        in_v = '0; ker_v = '0;
        step(); num_ch = 10'd2; in_next = 1'b1;
        step(); set_el(0, ONE, 32'h0, ONE, 32'h0);
        step();
        step(); set_el(0, 32'h0003_0000, 32'h0, ONE, 32'h0);
        chk("t4_next_P4", 64'(out_next), 64'h0);
        step(); in_next = 1'b0;
        chk("t4_nextA", 64'(out_next), 64'h1);
        step(); chk("t4_gap", 64'(out_next), 64'h0);
        chk("t4_outA", get_el(out_v, 0), {32'h0002_0000, 32'h0});
        step(); chk("t4_nextB", 64'(out_next), 64'h1);
        step(); chk("t4_outB", get_el(out_v, 0), {32'h0006_0000, 32'h0});
        chk("t4_after", 64'(out_next), 64'h0);

        // Reset aborts a partial N=3 group; a fresh N=1 beat of (7,0) follows
        set_el(0, 32'h0005_0000, 32'h0, ONE, 32'h0);
        step(); num_ch = 10'd3; in_next = 1'b1;
        step();
        step(); in_next = 1'b0; reset = 1'b1;
        step(); reset = 1'b0;
        chk("t5_rst_out", get_el(out_v, 0), 64'h0);
        chk("t5_rst_busy", 64'(busy), 64'h0);
        num_ch = 10'd1; in_next = 1'b1;
        step(); in_next = 1'b0; set_el(0, 32'h0007_0000, 32'h0, ONE, 32'h0);
        chk("t5_next_T1", 64'(out_next), 64'h0);
        step(); chk("t5_next_T2", 64'(out_next), 64'h0);
        step(); chk("t5_next_T3", 64'(out_next), 64'h1);
        step(); chk("t5_out", get_el(out_v, 0), {32'h0007_0000, 32'h0});

        // num_ch=0 acts as 1: (1,0)*(4,0)
        set_el(0, ONE, 32'h0, 32'h0004_0000, 32'h0);
        step(); num_ch = 10'd0; in_next = 1'b1;
        step(); in_next = 1'b0;
        step(); step(); chk("t6a_next", 64'(out_next), 64'h1);
        step(); chk("t6a_out", get_el(out_v, 0), {32'h0004_0000, 32'h0});

        // num_ch change mid-group is ignored: group closes after 2 beats of (1,0)
        set_el(0, ONE, 32'h0, ONE, 32'h0);
        step(); num_ch = 10'd2; in_next = 1'b1;
        step(); num_ch = 10'd5;
        step(); in_next = 1'b0;
        step(); step(); chk("t6b_next", 64'(out_next), 64'h1);
        step(); chk("t6b_out", get_el(out_v, 0), {32'h0002_0000, 32'h0});
        chk("t6b_busy", 64'(busy), 64'h0);
        chk("t6b_no_more", 64'(out_next), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
